// File: rtl/debouncer_edge.sv
// Button conditioner: two-flop synchroniser, stability-count filter, debounced level and press/release pulses.
// Define DEBOUNCE_REPEAT_EN to make press_pulse auto-repeat while the button is held.
module debouncer_edge #(
    parameter int STABLE_COUNT  = 500000,
    parameter int CNT_WIDTH     = 19,
    parameter bit ACTIVE_LOW    = 1'b1,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic btn_db,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse
);

    localparam logic                 IDLE_LVL = ACTIVE_LOW;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_COUNT - 1);

    // Reject configurations the filter cannot honour (window must fit the counter).
    if (STABLE_COUNT < 2 || STABLE_COUNT > (2 ** CNT_WIDTH) - 1) begin : g_bad_stable
        $error("debouncer_edge: STABLE_COUNT out of range for CNT_WIDTH");
    end
    if (REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_repeat
        $error("debouncer_edge: REPEAT_DELAY and REPEAT_PERIOD must be at least 2");
    end

    logic                 sync1_r;
    logic                 sync2_r;
    logic                 sample_s;
    logic [CNT_WIDTH-1:0] cnt_r;
    logic [CNT_WIDTH-1:0] cnt_nxt_s;
    logic                 pressed_r;
    logic                 pressed_nxt_s;
    logic                 press_pulse_r;
    logic                 release_pulse_r;
    logic                 press_evt_s;
    logic                 release_evt_s;
    logic                 flip_s;
    logic                 rep_fire_s;

    // Two-flop synchroniser for the asynchronous button input.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r <= IDLE_LVL;
            sync2_r <= IDLE_LVL;
        end else begin
            sync1_r <= btn_in;
            sync2_r <= sync1_r;
        end
    end

    // 1 = pressed, independent of board polarity.
    assign sample_s = sync2_r ^ ACTIVE_LOW;

    // Stability filter: any sample that agrees with the state restarts the window.
    always_comb begin
        cnt_nxt_s     = cnt_r;
        pressed_nxt_s = pressed_r;
        press_evt_s   = 1'b0;
        release_evt_s = 1'b0;
        flip_s        = 1'b0;
        if (sample_s == pressed_r) begin
            cnt_nxt_s = '0;
        end else if (cnt_r == CNT_LAST) begin
            flip_s        = 1'b1;
            pressed_nxt_s = sample_s;
            cnt_nxt_s     = '0;
            if (sample_s) begin
                press_evt_s = 1'b1;
            end else begin
                release_evt_s = 1'b1;
            end
        end else begin
            cnt_nxt_s = cnt_r + CNT_WIDTH'(1);
        end
    end

`ifdef DEBOUNCE_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

    logic [REP_W-1:0] rep_cnt_r;
    logic [REP_W-1:0] rep_cnt_nxt_s;
    logic             rep_armed_r;
    logic             rep_armed_nxt_s;

    // Repeat timer: initial delay first, then the period; cleared whenever the state changes or is released.
    always_comb begin
        rep_cnt_nxt_s   = rep_cnt_r;
        rep_armed_nxt_s = rep_armed_r;
        rep_fire_s      = 1'b0;
        if (!pressed_r || flip_s) begin
            rep_cnt_nxt_s   = '0;
            rep_armed_nxt_s = 1'b0;
        end else if (!rep_armed_r) begin
            if (rep_cnt_r == DELAY_LAST) begin
                rep_fire_s      = 1'b1;
                rep_cnt_nxt_s   = '0;
                rep_armed_nxt_s = 1'b1;
            end else begin
                rep_cnt_nxt_s = rep_cnt_r + REP_W'(1);
            end
        end else begin
            if (rep_cnt_r == PERIOD_LAST) begin
                rep_fire_s    = 1'b1;
                rep_cnt_nxt_s = '0;
            end else begin
                rep_cnt_nxt_s = rep_cnt_r + REP_W'(1);
            end
        end
    end

    // Repeat timer state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rep_cnt_r   <= '0;
            rep_armed_r <= 1'b0;
        end else begin
            rep_cnt_r   <= rep_cnt_nxt_s;
            rep_armed_r <= rep_armed_nxt_s;
        end
    end
`else
    assign rep_fire_s = 1'b0;
`endif

    // Filter state and registered pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r           <= '0;
            pressed_r       <= 1'b0;
            press_pulse_r   <= 1'b0;
            release_pulse_r <= 1'b0;
        end else begin
            cnt_r           <= cnt_nxt_s;
            pressed_r       <= pressed_nxt_s;
            press_pulse_r   <= press_evt_s | rep_fire_s;
            release_pulse_r <= release_evt_s;
        end
    end

    assign pressed       = pressed_r;
    assign btn_db        = pressed_r ^ ACTIVE_LOW;
    assign press_pulse   = press_pulse_r;
    assign release_pulse = release_pulse_r;

endmodule

// File: tb/tb_debouncer_edge.sv
// Directed bench for debouncer_edge with STABLE_COUNT=4, ACTIVE_LOW=1 (repeat checks follow DEBOUNCE_REPEAT_EN).
module tb_debouncer_edge;

    logic clk    = 1'b0;
    logic clk_en = 1'b0;
    logic reset;
    logic btn_in;
    logic btn_db;
    logic pressed;
    logic press_pulse;
    logic release_pulse;

    int checks = 0;
    int errors = 0;

`ifdef DEBOUNCE_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    debouncer_edge #(
        .STABLE_COUNT (4),
        .CNT_WIDTH    (3),
        .ACTIVE_LOW   (1'b1),
        .REPEAT_DELAY (8),
        .REPEAT_PERIOD(3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_in       (btn_in),
        .btn_db       (btn_db),
        .pressed      (pressed),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    typedef struct {
        logic btn;
        int   n;
        logic ep;
        logic epp;
        logic erp;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic ep, input logic epp, input logic erp);
        chk({tag, "/pressed"}, pressed, ep);
        chk({tag, "/btn_db"}, btn_db, ~ep);
        chk({tag, "/press_pulse"}, press_pulse, epp);
        chk({tag, "/release_pulse"}, release_pulse, erp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // clean press, glitches, excursion, clean release
        tbl[0]  = '{1'b0, 5,  1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1,  1'b1, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 20, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 3,  1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 10, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 4,  1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1,  1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1,  1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 3,  1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1,  1'b1, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 5,  1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 5,  1'b1, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1,  1'b0, 1'b0, 1'b1};
        tbl[13] = '{1'b1, 5,  1'b0, 1'b0, 1'b0};

        // Reset with the clock stopped
        reset  = 1'b0;
        btn_in = 1'b0;
        #3;
        chk_all("reset_noclk", 1'b0, 1'b0, 1'b0);
        btn_in = 1'b1;
        clk_en = 1'b1;
        step();
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk_all("idle_after_reset", 1'b0, 1'b0, 1'b0);
        end

        // Table-driven vectors
        for (int r = 0; r < 14; r++) begin
            btn_in = tbl[r].btn;
            for (int c = 0; c < tbl[r].n; c++) begin
                step();
                chk_all($sformatf("vec%0d.%0d", r, c), tbl[r].ep, tbl[r].epp, tbl[r].erp);
            end
        end

        // Bounce: toggle every 2 clocks for 20 clocks, then settle low
        for (int i = 0; i < 10; i++) begin
            btn_in = (i % 2 == 1) ? 1'b1 : 1'b0;
            repeat (2) begin
                step();
                chk_all("bounce", 1'b0, 1'b0, 1'b0);
            end
        end
        btn_in = 1'b0;
        for (int t = 1; t <= 11; t++) begin
            step();
            chk_all($sformatf("bounce_settle%0d", t), t >= 6, t == 6, 1'b0);
        end
        btn_in = 1'b1;
        for (int t = 1; t <= 11; t++) begin
            step();
            chk_all($sformatf("bounce_release%0d", t), t < 6, 1'b0, t == 6);
        end

        // Reset in the middle of a press window
        btn_in = 1'b0;
        repeat (3) begin
            step();
            chk_all("pre_reset", 1'b0, 1'b0, 1'b0);
        end
        reset = 1'b0;
        #1;
        chk_all("reset_async", 1'b0, 1'b0, 1'b0);
        step();
        chk_all("reset_held", 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        for (int t = 1; t <= 6; t++) begin
            step();
            chk_all($sformatf("post_reset%0d", t), t == 6, t == 6, 1'b0);
        end

        // Hold, then release: repeat pulses only with the feature enabled, none on the release edge
        for (int t = 1; t <= 20; t++) begin
            step();
            chk_all($sformatf("hold%0d", t), 1'b1,
                    REP_EN && (t == 8 || t == 11 || t == 14 || t == 17 || t == 20), 1'b0);
        end
        btn_in = 1'b1;
        for (int t = 21; t <= 31; t++) begin
            step();
            chk_all($sformatf("hold_release%0d", t), t < 26, REP_EN && (t == 23), t == 26);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
